// File: rtl/mux_n_1_rr_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg -- shared constants and types for the N:1 round-robin mux slice.
//   MODE_MANUAL / MODE_RR : encodings of the mode input
//   DEF_WIDTH / DEF_CHANNELS : default data width and channel count
//   out_state_e : output-stage occupancy (one-entry register)
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_MANUAL  = 1'b0;
    localparam logic MODE_RR      = 1'b1;

    localparam int   DEF_WIDTH    = 2;
    localparam int   DEF_CHANNELS = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mux_n_1_rr_if.sv
// -----------------------------------------------------------------------------
// mux_n_1_rr_if -- bus bundle between the N:1 mux and its environment.
//   mode, selector, valid_in, data_in, ready_out : driven by master
//   ready_in, data_out, valid_out, channel_out   : driven by slave (the mux)
//   parity_out (only with MUX_N_1_RR_PARITY_EN)  : driven by slave
// Modports: master (environment view), slave (mux view).
// -----------------------------------------------------------------------------
interface mux_n_1_rr_if #(
    parameter int WIDTH    = mux_pkg::DEF_WIDTH,
    parameter int CHANNELS = mux_pkg::DEF_CHANNELS
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      mode;
    logic [SEL_W-1:0]          selector;
    logic [CHANNELS-1:0]       valid_in;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       ready_in;
    logic [WIDTH-1:0]          data_out;
    logic                      valid_out;
    logic [SEL_W-1:0]          channel_out;
    logic                      ready_out;

`ifdef MUX_N_1_RR_PARITY_EN
    logic                      parity_out;

    modport master (
        output mode, selector, valid_in, data_in, ready_out,
        input  ready_in, data_out, valid_out, channel_out, parity_out
    );
    modport slave (
        input  mode, selector, valid_in, data_in, ready_out,
        output ready_in, data_out, valid_out, channel_out, parity_out
    );
`else
    modport master (
        output mode, selector, valid_in, data_in, ready_out,
        input  ready_in, data_out, valid_out, channel_out
    );
    modport slave (
        input  mode, selector, valid_in, data_in, ready_out,
        output ready_in, data_out, valid_out, channel_out
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter -- round-robin search plus last-grant pointer.
//   clk, reset_L : clock, async active-low reset (pointer -> CHANNELS-1)
//   req          : request vector
//   advance      : move pointer to the current grant (a transfer happened)
//   grant_oh     : one-hot grant
//   grant_idx    : grant index
//   grant_valid  : some request was found
// Search starts at (ptr+1) mod CHANNELS and wraps.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int CHANNELS = mux_pkg::DEF_CHANNELS,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant_oh,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_valid
);
    logic [SEL_W-1:0]      ptr_q;
    logic [SEL_W-1:0]      start;
    logic [2*CHANNELS-1:0] rot;
    int                    off_c;
    int                    idx_c;

    // Explicit wrap so non-power-of-two channel counts stay in range.
    assign start = (ptr_q == SEL_W'(CHANNELS-1)) ? '0 : ptr_q + SEL_W'(1);

    // Rotate requests so bit 0 is the highest-priority channel.
    assign rot = {req, req} >> start;

    always_comb begin
        grant_valid = 1'b0;
        grant_oh    = '0;
        off_c       = 0;
        for (int k = CHANNELS-1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_valid = 1'b1;
                off_c       = k;
            end
        end
        idx_c = int'(start) + off_c;
        if (idx_c >= CHANNELS) idx_c = idx_c - CHANNELS;
        grant_idx = idx_c[SEL_W-1:0];
        for (int i = 0; i < CHANNELS; i++)
            grant_oh[i] = grant_valid && (grant_idx == i[SEL_W-1:0]);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)     ptr_q <= SEL_W'(CHANNELS-1);
        else if (advance) ptr_q <= grant_idx;
    end

endmodule

// File: rtl/mux_n_1_rr.sv
// -----------------------------------------------------------------------------
// mux_n_1_rr -- N:1 data mux with manual or round-robin channel selection and
// a one-entry registered output stage.
//   clk     : clock
//   reset_L : async active-low reset
//   bus     : mux_n_1_rr_if.slave (mode, selector, valid_in/data_in/ready_in,
//             data_out/valid_out/channel_out/ready_out)
// Optional: define MUX_N_1_RR_PARITY_EN to add bus.parity_out, the XOR reduce
// of data_out, registered alongside it.
// -----------------------------------------------------------------------------
module mux_n_1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic         clk,
    input  logic         reset_L,
    mux_n_1_rr_if.slave  bus
);
    out_state_e          state_q, state_d;
    logic                load_en;
    logic                xfer;

    logic [CHANNELS-1:0] man_oh;
    logic                man_valid;
    logic [CHANNELS-1:0] rr_oh;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_valid;

    logic [CHANNELS-1:0] g_oh;
    logic [SEL_W-1:0]    g_idx;
    logic                g_valid;
    logic [WIDTH-1:0]    g_data;

    logic [WIDTH-1:0]    data_q;
    logic [SEL_W-1:0]    chan_q;

    assign load_en = (state_q == ST_EMPTY) || bus.ready_out;

    // Manual grant: an out-of-range selector matches no channel, so it
    // simply grants nothing.
    always_comb begin
        man_oh = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (bus.selector == i[SEL_W-1:0]) man_oh[i] = bus.valid_in[i];
    end
    assign man_valid = |man_oh;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clk         (clk),
        .reset_L     (reset_L),
        .req         (bus.valid_in),
        .advance     (xfer && (bus.mode == MODE_RR)),
        .grant_oh    (rr_oh),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    always_comb begin
        if (bus.mode == MODE_RR) begin
            g_oh    = rr_oh;
            g_idx   = rr_idx;
            g_valid = rr_valid;
        end else begin
            g_oh    = man_oh;
            g_idx   = bus.selector;
            g_valid = man_valid;
        end
    end

    // Reset gating keeps ready_in low while reset is held even though the
    // (cleared) output stage would otherwise look loadable.
    assign bus.ready_in = (reset_L && load_en && g_valid) ? g_oh : '0;
    assign xfer         = |(bus.ready_in & bus.valid_in);

    always_comb begin
        g_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (g_oh[i]) g_data = bus.data_in[i*WIDTH +: WIDTH];
    end

    // Output-stage occupancy.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer)                    state_d = ST_FULL;
            ST_FULL:  if (bus.ready_out && !xfer)  state_d = ST_EMPTY;
            default:                               state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q <= '0;
            chan_q <= '0;
        end else if (xfer) begin
            data_q <= g_data;
            chan_q <= g_idx;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.channel_out = chan_q;
    assign bus.valid_out   = (state_q == ST_FULL);

`ifdef MUX_N_1_RR_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)  par_q <= 1'b0;
        else if (xfer) par_q <= ^g_data;
    end
    assign bus.parity_out = par_q;
`endif

endmodule

// File: doc/mux_n_1_rr.md
MUX_N_1_RR -- requirements
Module: mux_n_1_rr

Interface
REQ-001 Parameter WIDTH, default 2, bits per data channel (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Localparam SEL_W = clog2(CHANNELS), width of selector and channel index; not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = manual (selector-driven), 1 = round-robin arbitration.
REQ-007 selector  input  SEL_W  channel index used in manual mode.
REQ-008 valid_in  input  CHANNELS  per-channel data-valid.
REQ-009 data_in  input  CHANNELS*WIDTH  packed inputs; channel i at [i*WIDTH +: WIDTH].
REQ-010 ready_in  output  CHANNELS  per-channel accept, combinational, at most one bit high.
REQ-011 data_out  output  WIDTH  registered selected data.
REQ-012 valid_out  output  1  data_out holds an undelivered word.
REQ-013 channel_out  output  SEL_W  registered source index of data_out.
REQ-014 ready_out  input  1  downstream accept.

Function
REQ-015 Output stage SHALL be a one-entry register with states EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-016 load_en SHALL be (!valid_out || ready_out); a full stage drained and refilled in the same cycle gives one word per cycle throughput.
REQ-017 Manual mode: grant = selector when selector < CHANNELS and valid_in[selector]=1; otherwise no grant.
REQ-018 Manual mode: selector >= CHANNELS SHALL grant nothing and never index out of range.
REQ-019 Round-robin mode: grant = first channel with valid_in=1 searching from (ptr+1) mod CHANNELS upward with wrap-around; none if valid_in=0.
REQ-020 ready_in[g] SHALL be 1 only for the granted channel g and only while load_en=1.
REQ-021 A transfer occurs when ready_in[g] && valid_in[g]; next edge: data_out=data_in[g], channel_out=g, valid_out=1.
REQ-022 Latency input-transfer to valid_out SHALL be exactly 1 cycle.
REQ-023 Output handshake completes when valid_out && ready_out; with no new transfer that cycle, valid_out clears next edge.
REQ-024 While valid_out=1 and ready_out=0, data_out and channel_out SHALL hold stable and all ready_in SHALL be 0.
REQ-025 ptr SHALL update to g only on a transfer in round-robin mode; manual-mode transfers leave ptr unchanged.
REQ-026 A mode or selector change SHALL affect only the next grant decision; a held output word is unaffected.

Reset
REQ-027 On reset_L=0, immediately: data_out=0, channel_out=0, valid_out=0, ptr=CHANNELS-1 (first round-robin grant favours channel 0).
REQ-028 Reset mid-operation SHALL discard any held word; ready_in SHALL be 0 while reset_L=0.
REQ-029 Reset deassertion is synchronous to clk by the environment; first transfer is possible on the first edge after release.

Configuration
REQ-030 Macro MUX_N_1_RR_PARITY_EN SHALL, when defined, add output parity_out (1 bit) = even parity (XOR reduce) of data_out, registered with data_out and reset to 0.
REQ-031 Without MUX_N_1_RR_PARITY_EN, parity_out and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Shared package mux_pkg SHALL hold MODE_MANUAL=0, MODE_RR=1 and the default WIDTH/CHANNELS constants.
REQ-033 Round-robin search plus ptr register SHALL be sub-module rr_arbiter (inputs: request vector, advance, ptr reset; outputs: grant one-hot, grant index, grant_valid).

Verification
REQ-034 Manual, CHANNELS=4, WIDTH=2: selector=2, valid_in=4'b0100, data ch2=2'b11, ready_out=1 -> ready_in=4'b0100; next cycle data_out=2'b11, channel_out=2, valid_out=1.
REQ-035 RR, all valid_in=1, ready_out=1 held 5 cycles after reset -> channel_out sequence 0,1,2,3,0.
REQ-036 Backpressure: valid_out=1, ready_out=0 for 3 cycles -> data_out/channel_out constant, ready_in=0; ready_out=1 -> word accepted and next word loaded same edge.
REQ-037 RR wrap with gaps: ptr=3, valid_in=4'b0010 -> grant 1; then valid_in=4'b1001 -> grant 3.
REQ-038 reset_L pulsed low mid-stream (valid_out=1) -> valid_out, data_out, channel_out go 0 without clk edge; first RR grant after release is channel 0.
REQ-039 Manual with CHANNELS=3, selector=3 and valid_in=3'b111 -> ready_in=0, valid_out stays 0.
